// File: rtl/ycbcr_pkg.sv
// Shared definitions for the RGB -> YCbCr stream converter: coefficient table,
// range offsets and clamp limits, input format codes and the SOF sideband bit.
package ycbcr_pkg;

  localparam int FMT_RGB565 = 0;
  localparam int FMT_RGB888 = 1;

  localparam int SOF_BIT = 0;

  localparam int ACC_W    = 18;
  localparam int ACC_FRAC = 8;
  localparam int V_W      = ACC_W - ACC_FRAC;
  localparam int SAT_W    = 11;
  localparam int ROUND    = 128;

  localparam int Y_OFF_STUDIO = 16;
  localparam int C_OFF        = 128;
  localparam int STUDIO_LO    = 16;
  localparam int STUDIO_Y_HI  = 235;
  localparam int STUDIO_C_HI  = 240;
  localparam int FULL_LO      = 0;
  localparam int FULL_HI      = 255;

  typedef logic signed [8:0]       coef_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  // Encoded as {std, full}, matching the cfg_active port.
  typedef enum logic [1:0] {
    SEL_601_STUDIO = 2'b00,
    SEL_601_FULL   = 2'b01,
    SEL_709_STUDIO = 2'b10,
    SEL_709_FULL   = 2'b11
  } csel_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Rows indexed by csel_e; columns Y(R,G,B), Cb(R,G,B), Cr(R,G,B), scaled by 256.
  localparam coef_t COEF_TBL [4][9] = '{
    '{ 9'sd66, 9'sd129, 9'sd25, -9'sd38, -9'sd74, 9'sd112, 9'sd112,  -9'sd94, -9'sd18 },
    '{ 9'sd77, 9'sd150, 9'sd29, -9'sd43, -9'sd85, 9'sd128, 9'sd128, -9'sd107, -9'sd21 },
    '{ 9'sd47, 9'sd157, 9'sd16, -9'sd26, -9'sd86, 9'sd112, 9'sd112, -9'sd102, -9'sd10 },
    '{ 9'sd54, 9'sd183, 9'sd19, -9'sd29, -9'sd99, 9'sd128, 9'sd128, -9'sd116, -9'sd12 }
  };

  function automatic rgb_t expand565(input logic [15:0] d);
    rgb_t p;
    p.r = {d[15:11], d[15:13]};
    p.g = {d[10:5],  d[10:9]};
    p.b = {d[4:0],   d[4:2]};
    return p;
  endfunction

endpackage

// File: rtl/ycbcr_mac.sv
// One output channel: the 3-term MAC feeds the S2 register; the round/offset/clamp
// half works on the registered accumulator and feeds the output register.
module ycbcr_mac
  import ycbcr_pkg::*;
(
  input  coef_t      k_r,
  input  coef_t      k_g,
  input  coef_t      k_b,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output acc_t       acc,
  input  acc_t       acc_in,
  input  logic       is_luma,
  input  logic       full,
  output logic [7:0] res
);

  logic signed [V_W-1:0]   v;
  logic signed [SAT_W:0]   sum;
  logic signed [SAT_W-1:0] sat;
  logic signed [SAT_W-1:0] lo;
  logic signed [SAT_W-1:0] hi;

  always_comb begin
    acc = acc_t'(k_r) * acc_t'({10'd0, r})
        + acc_t'(k_g) * acc_t'({10'd0, g})
        + acc_t'(k_b) * acc_t'({10'd0, b})
        + acc_t'(ROUND);
  end

  always_comb begin
    v   = V_W'(acc_in >>> ACC_FRAC);
    sum = (SAT_W+1)'(v) + (is_luma ? (full ? 12'sd0 : 12'(Y_OFF_STUDIO)) : 12'(C_OFF));

    // Bound to the 11-bit signed range first so the final clamp can never see a wrapped value.
    if (sum > 12'sd1023) begin
      sat = 11'sd1023;
    end else if (sum < -12'sd1024) begin
      sat = {1'b1, 10'd0};
    end else begin
      sat = sum[SAT_W-1:0];
    end

    lo = full ? 11'(FULL_LO) : 11'(STUDIO_LO);
    hi = full ? 11'(FULL_HI) : (is_luma ? 11'(STUDIO_Y_HI) : 11'(STUDIO_C_HI));

    if (sat < lo) begin
      res = lo[7:0];
    end else if (sat > hi) begin
      res = hi[7:0];
    end else begin
      res = sat[7:0];
    end
  end

endmodule

// File: rtl/ycbcr_convert_stream.sv
// RGB565/RGB888 -> YCbCr 4:4:4 stream converter, 3-stage pipeline, 1 beat/clk.
// One global advance enable stalls every stage together; s_ready is combinational from m_ready.
module ycbcr_convert_stream
  import ycbcr_pkg::*;
#(
  parameter int IN_FMT = FMT_RGB565,
  parameter int USER_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [23:0]       s_data,
  input  logic [USER_W-1:0] s_user,
  input  logic              cfg_std,
  input  logic              cfg_full,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_y,
  output logic [7:0]        m_cb,
  output logic [7:0]        m_cr,
  output logic [USER_W-1:0] m_user,
  output logic [1:0]        cfg_active
);

  logic  en;
  logic  accept;
  logic  sof;
  rgb_t  in_rgb;
  csel_e in_sel;

  logic              s1_vld_q,  s1_vld_d;
  rgb_t              s1_rgb_q,  s1_rgb_d;
  csel_e             s1_sel_q,  s1_sel_d;
  logic [USER_W-1:0] s1_user_q, s1_user_d;

  logic              s2_vld_q,  s2_vld_d;
  acc_t              s2_acc_q [3];
  acc_t              s2_acc_d [3];
  logic              s2_full_q, s2_full_d;
  logic [USER_W-1:0] s2_user_q, s2_user_d;

  logic              m_valid_q, m_valid_d;
  logic [7:0]        m_y_q,     m_y_d;
  logic [7:0]        m_cb_q,    m_cb_d;
  logic [7:0]        m_cr_q,    m_cr_d;
  logic [USER_W-1:0] m_user_q,  m_user_d;
  logic [1:0]        cfg_active_q, cfg_active_d;

  acc_t       mac_acc [3];
  logic [7:0] mac_res [3];

  // Coefficients come from the select registered with the pixel, so in-flight
  // beats keep the setting they entered with.
  for (genvar ch = 0; ch < 3; ch++) begin : g_mac
    ycbcr_mac u_mac (
      .k_r     (COEF_TBL[s1_sel_q][3*ch]),
      .k_g     (COEF_TBL[s1_sel_q][3*ch+1]),
      .k_b     (COEF_TBL[s1_sel_q][3*ch+2]),
      .r       (s1_rgb_q.r),
      .g       (s1_rgb_q.g),
      .b       (s1_rgb_q.b),
      .acc     (mac_acc[ch]),
      .acc_in  (s2_acc_q[ch]),
      .is_luma (ch == 0),
      .full    (s2_full_q),
      .res     (mac_res[ch])
    );
  end

  always_comb begin
    en      = m_ready || !m_valid_q;
    s_ready = en && rst_n;
    accept  = s_valid && s_ready;
    sof     = s_user[SOF_BIT];
    in_sel  = sof ? csel_e'({cfg_std, cfg_full}) : csel_e'(cfg_active_q);
    in_rgb  = (IN_FMT == FMT_RGB888) ? rgb_t'(s_data) : expand565(s_data[15:0]);

    s1_vld_d     = s1_vld_q;
    s1_rgb_d     = s1_rgb_q;
    s1_sel_d     = s1_sel_q;
    s1_user_d    = s1_user_q;
    s2_vld_d     = s2_vld_q;
    s2_acc_d     = s2_acc_q;
    s2_full_d    = s2_full_q;
    s2_user_d    = s2_user_q;
    m_valid_d    = m_valid_q;
    m_y_d        = m_y_q;
    m_cb_d       = m_cb_q;
    m_cr_d       = m_cr_q;
    m_user_d     = m_user_q;
    cfg_active_d = cfg_active_q;

    if (accept && sof) begin
      cfg_active_d = {cfg_std, cfg_full};
    end

    if (en) begin
      s1_vld_d = accept;
      if (accept) begin
        s1_rgb_d  = in_rgb;
        s1_sel_d  = in_sel;
        s1_user_d = s_user;
      end
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_acc_d  = mac_acc;
        s2_full_d = (s1_sel_q == SEL_601_FULL) || (s1_sel_q == SEL_709_FULL);
        s2_user_d = s1_user_q;
      end
      m_valid_d = s2_vld_q;
      if (s2_vld_q) begin
        m_y_d    = mac_res[0];
        m_cb_d   = mac_res[1];
        m_cr_d   = mac_res[2];
        m_user_d = s2_user_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q     <= 1'b0;
      s1_rgb_q     <= '0;
      s1_sel_q     <= SEL_601_STUDIO;
      s1_user_q    <= '0;
      s2_vld_q     <= 1'b0;
      for (int i = 0; i < 3; i++) s2_acc_q[i] <= '0;
      s2_full_q    <= 1'b0;
      s2_user_q    <= '0;
      m_valid_q    <= 1'b0;
      m_y_q        <= '0;
      m_cb_q       <= '0;
      m_cr_q       <= '0;
      m_user_q     <= '0;
      cfg_active_q <= '0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_rgb_q     <= s1_rgb_d;
      s1_sel_q     <= s1_sel_d;
      s1_user_q    <= s1_user_d;
      s2_vld_q     <= s2_vld_d;
      for (int i = 0; i < 3; i++) s2_acc_q[i] <= s2_acc_d[i];
      s2_full_q    <= s2_full_d;
      s2_user_q    <= s2_user_d;
      m_valid_q    <= m_valid_d;
      m_y_q        <= m_y_d;
      m_cb_q       <= m_cb_d;
      m_cr_q       <= m_cr_d;
      m_user_q     <= m_user_d;
      cfg_active_q <= cfg_active_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_y        = m_y_q;
  assign m_cb       = m_cb_q;
  assign m_cr       = m_cr_q;
  assign m_user     = m_user_q;
  assign cfg_active = cfg_active_q;

endmodule

// File: tb/tb_ycbcr_convert_stream.sv
// Bench for ycbcr_convert_stream: one RGB565 and one RGB888 instance share all inputs.
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_ycbcr_convert_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic [23:0] s_data;
  logic [1:0]  s_user;
  logic        cfg_std;
  logic        cfg_full;
  logic        m_ready;

  logic       s_ready0, m_valid0, s_ready1, m_valid1;
  logic [7:0] m_y0, m_cb0, m_cr0, m_y1, m_cb1, m_cr1;
  logic [1:0] m_user0, cfg_active0, m_user1, cfg_active1;

  int checks = 0;
  int errors = 0;

  int K [4][9] = '{
    '{66, 129, 25, -38, -74, 112, 112,  -94, -18},
    '{77, 150, 29, -43, -85, 128, 128, -107, -21},
    '{47, 157, 16, -26, -86, 112, 112, -102, -10},
    '{54, 183, 19, -29, -99, 128, 128, -116, -12}
  };

  always #5 clk = ~clk;

  ycbcr_convert_stream #(.IN_FMT(0), .USER_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
    .s_user(s_user), .cfg_std(cfg_std), .cfg_full(cfg_full), .m_valid(m_valid0),
    .m_ready(m_ready), .m_y(m_y0), .m_cb(m_cb0), .m_cr(m_cr0), .m_user(m_user0),
    .cfg_active(cfg_active0)
  );

  ycbcr_convert_stream #(.IN_FMT(1), .USER_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .s_user(s_user), .cfg_std(cfg_std), .cfg_full(cfg_full), .m_valid(m_valid1),
    .m_ready(m_ready), .m_y(m_y1), .m_cb(m_cb1), .m_cr(m_cr1), .m_user(m_user1),
    .cfg_active(cfg_active1)
  );

  // Reference conversion straight from the colour-space formulas, returns {Y,Cb,Cr}.
  function automatic logic [23:0] ref_pix(input int fmt, input logic [23:0] d, input logic [1:0] sel);
    int r, g, b, acc, v, lo, hi;
    logic [7:0] o [3];
    if (fmt == 0) begin
      r = 8 * d[15:11] + d[15:13];
      g = 4 * d[10:5] + d[10:9];
      b = 8 * d[4:0] + d[4:2];
    end else begin
      r = d[23:16];
      g = d[15:8];
      b = d[7:0];
    end
    for (int ch = 0; ch < 3; ch++) begin
      acc = K[sel][3*ch] * r + K[sel][3*ch+1] * g + K[sel][3*ch+2] * b + 128;
      v   = acc >>> 8;
      v   = v + ((ch == 0) ? (sel[0] ? 0 : 16) : 128);
      lo  = sel[0] ? 0 : 16;
      hi  = sel[0] ? 255 : ((ch == 0) ? 235 : 240);
      if (v < lo) v = lo;
      if (v > hi) v = hi;
      o[ch] = v[7:0];
    end
    return {o[0], o[1], o[2]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b1; s_data = 24'hABCDEF; s_user = 2'b01;
    cfg_std = 1'b1; cfg_full = 1'b1; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({s_ready0, s_ready1} !== 2'b00) begin
      errors++; $display("FAIL reset_s_ready got=%b exp=00", {s_ready0, s_ready1});
    end
    checks++;
    if ({m_valid0, m_y0, m_cb0, m_cr0, m_user0, cfg_active0} !== 29'd0) begin
      errors++; $display("FAIL reset_outputs0 got=%h exp=0", {m_valid0, m_y0, m_cb0, m_cr0, m_user0, cfg_active0});
    end
    checks++;
    if ({m_valid1, m_y1, m_cb1, m_cr1, m_user1, cfg_active1} !== 29'd0) begin
      errors++; $display("FAIL reset_outputs1 got=%h exp=0", {m_valid1, m_y1, m_cb1, m_cr1, m_user1, cfg_active1});
    end
    @(negedge clk);
    rst_n = 1'b1; s_valid = 1'b0; s_user = 2'b00; cfg_std = 1'b0; cfg_full = 1'b0;
  endtask

  task automatic test_565_basic();
    logic [23:0] din  [2];
    logic [23:0] dexp [2];
    din[0] = 24'h00FFFF; dexp[0] = {8'd235, 8'd128, 8'd128};
    din[1] = 24'h000000; dexp[1] = {8'd16, 8'd128, 8'd128};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      m_ready = 1'b1; s_user = 2'b00; s_valid = (c < 2);
      if (c < 2) s_data = din[c];
      #1;
      if (c < 2) begin
        checks++;
        if (s_ready0 !== 1'b1) begin
          errors++; $display("FAIL b2b_s_ready c=%0d got=%b exp=1", c, s_ready0);
        end
      end
      if (c == 3 || c == 4) begin
        checks++;
        if ({m_valid0, m_y0, m_cb0, m_cr0} !== {1'b1, dexp[c-3]}) begin
          errors++; $display("FAIL rgb565_pix c=%0d got=%h exp=%h", c, {m_valid0, m_y0, m_cb0, m_cr0}, {1'b1, dexp[c-3]});
        end
      end else begin
        checks++;
        if (m_valid0 !== 1'b0) begin
          errors++; $display("FAIL rgb565_latency c=%0d got m_valid=%b exp=0", c, m_valid0);
        end
      end
    end
  endtask

  task automatic test_888_full_sof();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      m_ready = 1'b1;
      if (c == 0) begin
        s_valid = 1'b1; s_data = 24'hFF0000; s_user = 2'b01; cfg_std = 1'b0; cfg_full = 1'b1;
      end else begin
        s_valid = 1'b0; s_user = 2'b00; cfg_std = 1'b1; cfg_full = 1'b0;
      end
      #1;
      if (c >= 1) begin
        checks++;
        if (cfg_active1 !== 2'b01) begin
          errors++; $display("FAIL cfg_601_full c=%0d got=%b exp=01", c, cfg_active1);
        end
      end
      if (c == 3) begin
        checks++;
        if ({m_valid1, m_y1, m_cb1, m_cr1, m_user1} !== {1'b1, 8'd77, 8'd85, 8'd255, 2'b01}) begin
          errors++; $display("FAIL pix_601_full got=%h exp=%h", {m_valid1, m_y1, m_cb1, m_cr1, m_user1}, {1'b1, 8'd77, 8'd85, 8'd255, 2'b01});
        end
      end else begin
        checks++;
        if (m_valid1 !== 1'b0) begin
          errors++; $display("FAIL lat_601_full c=%0d got m_valid=%b exp=0", c, m_valid1);
        end
      end
    end
  endtask

  task automatic test_709_midframe();
    logic [1:0] exp_user;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      m_ready = 1'b1; s_data = 24'hFF0000;
      case (c)
        0:       begin s_valid = 1'b1; s_user = 2'b01; cfg_std = 1'b1; cfg_full = 1'b0; end
        1:       begin s_valid = 1'b1; s_user = 2'b10; cfg_std = 1'b0; cfg_full = 1'b1; end
        2:       begin s_valid = 1'b1; s_user = 2'b10; cfg_std = 1'b1; cfg_full = 1'b1; end
        default: begin s_valid = 1'b0; s_user = 2'b00; cfg_std = 1'b0; cfg_full = 1'b0; end
      endcase
      #1;
      if (c >= 1) begin
        checks++;
        if (cfg_active1 !== 2'b10) begin
          errors++; $display("FAIL cfg_709_studio c=%0d got=%b exp=10", c, cfg_active1);
        end
      end
      if (c >= 3 && c <= 5) begin
        exp_user = (c == 3) ? 2'b01 : 2'b10;
        checks++;
        if ({m_valid1, m_y1, m_cb1, m_cr1, m_user1} !== {1'b1, 8'd63, 8'd102, 8'd240, exp_user}) begin
          errors++; $display("FAIL pix_709_midframe c=%0d got=%h exp=%h", c, {m_valid1, m_y1, m_cb1, m_cr1, m_user1}, {1'b1, 8'd63, 8'd102, 8'd240, exp_user});
        end
      end else begin
        checks++;
        if (m_valid1 !== 1'b0) begin
          errors++; $display("FAIL lat_709 c=%0d got m_valid=%b exp=0", c, m_valid1);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [23:0] q_p0 [$];
    logic [23:0] q_p1 [$];
    logic [1:0]  q_u  [$];
    logic [1:0]  cfg_m, sel;
    logic        held;
    logic [25:0] hold0, hold1;
    logic [23:0] e0, e1;
    logic [1:0]  eu;
    int acc_n, cyc;
    acc_n = 0; cyc = 0; held = 1'b0; hold0 = '0; hold1 = '0;
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cfg_m = 2'b00;
    while ((acc_n < 1000 || q_u.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      s_valid  = (acc_n < 1000) && ($urandom_range(0, 3) != 0);
      s_data   = 24'($urandom);
      s_user   = {1'($urandom), 1'($urandom_range(0, 15) == 0)};
      cfg_std  = 1'($urandom);
      cfg_full = 1'($urandom);
      m_ready  = 1'($urandom);
      #1;
      if (held) begin
        checks++;
        if ({m_valid0, m_y0, m_cb0, m_cr0, m_user0, m_valid1, m_y1, m_cb1, m_cr1, m_user1} !== {1'b1, hold0, 1'b1, hold1}) begin
          errors++; $display("FAIL stall_stable cyc=%0d got=%h/%h exp=%h/%h", cyc, {m_y0, m_cb0, m_cr0, m_user0}, {m_y1, m_cb1, m_cr1, m_user1}, hold0, hold1);
        end
      end
      checks++;
      if ({s_ready0, m_valid0, cfg_active0, cfg_active1} !== {s_ready1, m_valid1, cfg_m, cfg_m}) begin
        errors++; $display("FAIL rand_ctrl cyc=%0d got rdy=%b%b vld=%b%b cfg=%b/%b exp cfg=%b", cyc, s_ready0, s_ready1, m_valid0, m_valid1, cfg_active0, cfg_active1, cfg_m);
      end
      if (m_valid0 && m_ready) begin
        checks++;
        if (q_u.size() == 0) begin
          errors++; $display("FAIL rand_spurious cyc=%0d got=%h exp=none", cyc, {m_y0, m_cb0, m_cr0});
        end else begin
          e0 = q_p0.pop_front(); e1 = q_p1.pop_front(); eu = q_u.pop_front();
          if ({m_y0, m_cb0, m_cr0, m_user0, m_y1, m_cb1, m_cr1, m_user1} !== {e0, eu, e1, eu}) begin
            errors++; $display("FAIL rand_pix cyc=%0d got=%h %b / %h %b exp=%h / %h %b", cyc, {m_y0, m_cb0, m_cr0}, m_user0, {m_y1, m_cb1, m_cr1}, m_user1, e0, e1, eu);
          end
        end
      end
      held  = m_valid0 && !m_ready;
      hold0 = {m_y0, m_cb0, m_cr0, m_user0};
      hold1 = {m_y1, m_cb1, m_cr1, m_user1};
      if (s_valid && s_ready0) begin
        sel = s_user[0] ? {cfg_std, cfg_full} : cfg_m;
        q_p0.push_back(ref_pix(0, s_data, sel));
        q_p1.push_back(ref_pix(1, s_data, sel));
        q_u.push_back(s_user);
        if (s_user[0]) cfg_m = {cfg_std, cfg_full};
        acc_n++;
      end
      cyc++;
    end
    checks++;
    if (acc_n != 1000 || q_u.size() != 0) begin
      errors++; $display("FAIL rand_timeout accepted=%0d pending=%0d exp 1000/0", acc_n, q_u.size());
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      s_valid = 1'b0; m_ready = 1'b1;
      #1;
      checks++;
      if ({m_valid0, m_valid1} !== 2'b00) begin
        errors++; $display("FAIL rand_extra c=%0d got=%b exp=00", c, {m_valid0, m_valid1});
      end
    end
  endtask

  task automatic test_reset_inflight();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      m_ready = 1'b1; cfg_std = 1'b1; cfg_full = 1'b1;
      s_data = 24'($urandom);
      s_user = (c == 0) ? 2'b01 : 2'b10;
      s_valid = (c <= 3);
      rst_n = (c != 3);
      #1;
      if (c == 3) begin
        checks++;
        if ({s_ready0, s_ready1} !== 2'b00) begin
          errors++; $display("FAIL inflight_s_ready got=%b exp=00", {s_ready0, s_ready1});
        end
      end
      if (c == 4) begin
        checks++;
        if ({cfg_active0, cfg_active1} !== 4'b0000) begin
          errors++; $display("FAIL inflight_cfg got=%b exp=0000", {cfg_active0, cfg_active1});
        end
      end
      if (c >= 4) begin
        checks++;
        if ({m_valid0, m_valid1} !== 2'b00) begin
          errors++; $display("FAIL inflight_stale c=%0d got=%b exp=00", c, {m_valid0, m_valid1});
        end
      end
    end
  endtask

  task automatic test_sof_stall();
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      s_data = (c == 0) ? 24'h000000 : 24'hFF0000;
      s_valid = (c == 0) || (c >= 3 && c <= 8);
      s_user = (c >= 3) ? 2'b01 : 2'b00;
      m_ready = (c >= 8);
      if (c == 8) begin
        cfg_std = 1'b1; cfg_full = 1'b0;
      end else begin
        cfg_std = c[0]; cfg_full = 1'b1;
      end
      #1;
      if (c >= 3 && c <= 8) begin
        checks++;
        if ({s_ready1, cfg_active1, m_valid1, m_y1, m_cb1, m_cr1, m_user1} !== {(c == 8), 2'b00, 1'b1, 8'd16, 8'd128, 8'd128, 2'b00}) begin
          errors++; $display("FAIL sof_stall_hold c=%0d got=%h exp=%h", c, {s_ready1, cfg_active1, m_valid1, m_y1, m_cb1, m_cr1, m_user1}, {(c == 8), 2'b00, 1'b1, 8'd16, 8'd128, 8'd128, 2'b00});
        end
      end
      if (c >= 9) begin
        checks++;
        if (cfg_active1 !== 2'b10) begin
          errors++; $display("FAIL sof_stall_cfg c=%0d got=%b exp=10", c, cfg_active1);
        end
      end
      if (c == 11) begin
        checks++;
        if ({m_valid1, m_y1, m_cb1, m_cr1, m_user1} !== {1'b1, 8'd63, 8'd102, 8'd240, 2'b01}) begin
          errors++; $display("FAIL sof_stall_pix got=%h exp=%h", {m_valid1, m_y1, m_cb1, m_cr1, m_user1}, {1'b1, 8'd63, 8'd102, 8'd240, 2'b01});
        end
      end else if (c == 9 || c == 10 || c == 12) begin
        checks++;
        if (m_valid1 !== 1'b0) begin
          errors++; $display("FAIL sof_stall_lat c=%0d got m_valid=%b exp=0", c, m_valid1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_565_basic();
    test_888_full_sof();
    test_709_midframe();
    test_random();
    test_reset_inflight();
    test_sof_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
